magic_commit_queue: RTL and testbench

Elastic commit-trace buffer between the core's retirement ports and the cosim checker. Each cycle it captures up to COMMITS retired instructions plus an optional trap event, and stores them in program order in a circular queue. It drains one event per handshake to the downstream checker. This decouples multi-wide retirement from the single-event-per-call checker and makes lost events explicit instead of silent.

---
 rtl/magic_commit_queue.sv | 139 +++++++++++++
 tb/tb_magic_commit_queue.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/magic_commit_queue.sv
// magic_commit_queue: elastic commit-trace buffer, up to COMMITS retirements per cycle in, one event out per handshake.
// Optional feature macro COMMIT_QUEUE_TRAP_EN: capture trap_valid/trap_cause as an extra entry written after the lanes.
module magic_commit_queue #(
   parameter int COMMITS = 2,
   parameter int DEPTH   = 8,
   parameter int XLEN    = 64
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [COMMITS-1:0]      in_valid,
   input  logic [COMMITS*XLEN-1:0] in_pc,
   input  logic [COMMITS*32-1:0]   in_insn,
   input  logic [COMMITS-1:0]      in_wen,
   input  logic [COMMITS*5-1:0]    in_waddr,
   input  logic [COMMITS*XLEN-1:0] in_wdata,
   input  logic                    trap_valid,
   input  logic [XLEN-1:0]         trap_cause,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [XLEN-1:0]         out_pc,
   output logic [31:0]             out_insn,
   output logic                    out_wen,
   output logic [4:0]              out_waddr,
   output logic [XLEN-1:0]         out_wdata,
   output logic                    out_trap,
   output logic [XLEN-1:0]         out_cause,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [XLEN-1:0] mem_pc    [DEPTH];
   logic [31:0]     mem_insn  [DEPTH];
   logic            mem_wen   [DEPTH];
   logic [4:0]      mem_waddr [DEPTH];
   logic [XLEN-1:0] mem_wdata [DEPTH];
`ifdef COMMIT_QUEUE_TRAP_EN
   logic            mem_trap  [DEPTH];
   logic [XLEN-1:0] mem_cause [DEPTH];
   logic [PW-1:0]   trap_idx;
`else
   logic            unused_trap;
   assign unused_trap = ^{trap_valid, trap_cause};
`endif

   logic [PW-1:0] head, tail;
   logic [PW-1:0] lane_idx [COMMITS];
   logic [CW-1:0] n_commit, req, free_space;
   logic          deq_fire, accept;

   assign out_valid = (count != '0);
   assign deq_fire  = out_valid && out_ready;

   // Valid lanes are compacted: each lane lands at tail + (number of older valid lanes).
   always_comb begin
      n_commit = '0;
      for (int unsigned i = 0; i < COMMITS; i++) begin
         lane_idx[i] = tail + n_commit[PW-1:0];
         n_commit    = n_commit + CW'(in_valid[i]);
      end
`ifdef COMMIT_QUEUE_TRAP_EN
      trap_idx = tail + n_commit[PW-1:0];
      req      = n_commit + CW'(trap_valid);
`else
      req      = n_commit;
`endif
      free_space = CW'(DEPTH) - count + CW'(deq_fire);
      accept     = (req <= free_space);
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         for (int unsigned i = 0; i < COMMITS; i++) begin
            if (in_valid[i]) begin
               mem_pc[lane_idx[i]]    <= in_pc[i*XLEN +: XLEN];
               mem_insn[lane_idx[i]]  <= in_insn[i*32 +: 32];
               mem_wen[lane_idx[i]]   <= in_wen[i];
               mem_waddr[lane_idx[i]] <= in_wen[i] ? in_waddr[i*5 +: 5] : '0;
               mem_wdata[lane_idx[i]] <= in_wen[i] ? in_wdata[i*XLEN +: XLEN] : '0;
`ifdef COMMIT_QUEUE_TRAP_EN
               mem_trap[lane_idx[i]]  <= 1'b0;
               mem_cause[lane_idx[i]] <= '0;
`endif
            end
         end
`ifdef COMMIT_QUEUE_TRAP_EN
         if (trap_valid) begin
            mem_pc[trap_idx]    <= '0;
            mem_insn[trap_idx]  <= '0;
            mem_wen[trap_idx]   <= 1'b0;
            mem_waddr[trap_idx] <= '0;
            mem_wdata[trap_idx] <= '0;
            mem_trap[trap_idx]  <= 1'b1;
            mem_cause[trap_idx] <= trap_cause;
         end
`endif
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (deq_fire) head <= head + 1'b1;
         if (accept) begin
            tail  <= tail + req[PW-1:0];
            count <= count + req - CW'(deq_fire);
         end else begin
            count    <= count - CW'(deq_fire);
            overflow <= 1'b1;
         end
      end
   end

   always_comb begin
      out_pc    = '0;
      out_insn  = '0;
      out_wen   = 1'b0;
      out_waddr = '0;
      out_wdata = '0;
      out_trap  = 1'b0;
      out_cause = '0;
      if (out_valid) begin
         out_pc    = mem_pc[head];
         out_insn  = mem_insn[head];
         out_wen   = mem_wen[head];
         out_waddr = mem_waddr[head];
         out_wdata = mem_wdata[head];
`ifdef COMMIT_QUEUE_TRAP_EN
         out_trap  = mem_trap[head];
         out_cause = mem_cause[head];
`endif
      end
   end
endmodule

// File: tb/tb_magic_commit_queue.sv
// Self-checking bench for magic_commit_queue: queue-based reference model plus directed literal checks.
module tb_magic_commit_queue;
   localparam int COMMITS = 2;
   localparam int DEPTH   = 8;
   localparam int XLEN    = 64;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] insn;
      logic        wen;
      logic [4:0]  waddr;
      logic [63:0] wdata;
      logic        trap;
      logic [63:0] cause;
   } entry_t;

   logic                    clock = 1'b0;
   logic                    reset = 1'b0;
   logic [COMMITS-1:0]      in_valid;
   logic [COMMITS*XLEN-1:0] in_pc;
   logic [COMMITS*32-1:0]   in_insn;
   logic [COMMITS-1:0]      in_wen;
   logic [COMMITS*5-1:0]    in_waddr;
   logic [COMMITS*XLEN-1:0] in_wdata;
   logic                    trap_valid;
   logic [XLEN-1:0]         trap_cause;
   logic                    out_valid;
   logic                    out_ready;
   logic [XLEN-1:0]         out_pc;
   logic [31:0]             out_insn;
   logic                    out_wen;
   logic [4:0]              out_waddr;
   logic [XLEN-1:0]         out_wdata;
   logic                    out_trap;
   logic [XLEN-1:0]         out_cause;
   logic [$clog2(DEPTH):0]  count;
   logic                    overflow;

   int n_cmp = 0;
   int n_err = 0;

   entry_t mq[$];
   logic   m_ovf = 1'b0;

   magic_commit_queue #(.COMMITS(COMMITS), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_pc(in_pc), .in_insn(in_insn), .in_wen(in_wen),
      .in_waddr(in_waddr), .in_wdata(in_wdata),
      .trap_valid(trap_valid), .trap_cause(trap_cause),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_insn(out_insn), .out_wen(out_wen), .out_waddr(out_waddr),
      .out_wdata(out_wdata), .out_trap(out_trap), .out_cause(out_cause),
      .count(count), .overflow(overflow)
   );

   always #5 clock = ~clock;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: a queue of events; each edge is dequeue-then-all-or-nothing append.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         mq.delete();
         m_ovf = 1'b0;
      end else begin
         entry_t ev[$];
         entry_t e;
         int     free;
         ev.delete();
         for (int l = 0; l < COMMITS; l++) begin
            if (in_valid[l]) begin
               e       = '0;
               e.pc    = in_pc[l*XLEN +: XLEN];
               e.insn  = in_insn[l*32 +: 32];
               e.wen   = in_wen[l];
               e.waddr = in_wen[l] ? in_waddr[l*5 +: 5] : 5'd0;
               e.wdata = in_wen[l] ? in_wdata[l*XLEN +: XLEN] : 64'd0;
               ev.push_back(e);
            end
         end
`ifdef COMMIT_QUEUE_TRAP_EN
         if (trap_valid) begin
            e       = '0;
            e.trap  = 1'b1;
            e.cause = trap_cause;
            ev.push_back(e);
         end
`endif
         free = DEPTH - mq.size();
         if (mq.size() > 0 && out_ready) begin
            void'(mq.pop_front());
            free++;
         end
         if (ev.size() <= free) begin
            foreach (ev[k]) mq.push_back(ev[k]);
         end else begin
            m_ovf = 1'b1;
         end
      end
   end

   always @(negedge clock) begin
      if (reset) begin
         entry_t h;
         h = (mq.size() > 0) ? mq[0] : '0;
         check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
         check("out_pc", out_pc, h.pc);
         check("out_insn", 64'(out_insn), 64'(h.insn));
         check("out_wen", 64'(out_wen), 64'(h.wen));
         check("out_waddr", 64'(out_waddr), 64'(h.waddr));
         check("out_wdata", out_wdata, h.wdata);
         check("out_trap", 64'(out_trap), 64'(h.trap));
         check("out_cause", out_cause, h.cause);
         check("count", 64'(count), 64'(mq.size()));
         check("overflow", 64'(overflow), 64'(m_ovf));
      end
   end

   task automatic idle();
      in_valid   = '0;
      in_pc      = '0;
      in_insn    = '0;
      in_wen     = '0;
      in_waddr   = '0;
      in_wdata   = '0;
      trap_valid = 1'b0;
      trap_cause = '0;
   endtask

   task automatic set_lane(input int l, input logic [63:0] pc, input logic [31:0] insn,
                           input logic wen, input logic [4:0] waddr, input logic [63:0] wdata);
      in_valid[l]           = 1'b1;
      in_pc[l*XLEN +: XLEN] = pc;
      in_insn[l*32 +: 32]   = insn;
      in_wen[l]             = wen;
      in_waddr[l*5 +: 5]    = waddr;
      in_wdata[l*XLEN +: XLEN] = wdata;
   endtask

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic fill_pairs(input int n);
      for (int k = 0; k < n; k++) begin
         idle();
         set_lane(0, 64'h1000 + 64'(k * 8), 32'h13, 1'b1, 5'(k + 1), 64'(k));
         set_lane(1, 64'h1004 + 64'(k * 8), 32'h13, 1'b0, 5'd7, 64'hffff);
         cyc();
      end
      idle();
   endtask

   task automatic rand_inputs(input int ready_pct);
      in_valid   = COMMITS'($urandom);
      in_pc      = {$urandom, $urandom, $urandom, $urandom};
      in_insn    = {$urandom, $urandom};
      in_wen     = COMMITS'($urandom);
      in_waddr   = 10'($urandom);
      in_wdata   = {$urandom, $urandom, $urandom, $urandom};
      trap_valid = ($urandom_range(0, 3) == 0);
      trap_cause = {$urandom, $urandom};
      out_ready  = ($urandom_range(0, 99) < ready_pct);
   endtask

   initial begin
      idle();
      out_ready = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      check("rst_pc", out_pc, 64'd0);
      reset = 1'b1;

      // single commit with 1-cycle latency
      cyc();
      set_lane(0, 64'h8000_0000, 32'h0000_0013, 1'b0, 5'd3, 64'h55);
      out_ready = 1'b1;
      cyc();
      idle();
      @(negedge clock);
      check("single_valid", 64'(out_valid), 64'd1);
      check("single_pc", out_pc, 64'h8000_0000);
      check("single_wen", 64'(out_wen), 64'd0);
      check("single_waddr", 64'(out_waddr), 64'd0);
      cyc();
      @(negedge clock);
      check("single_drained", 64'(out_valid), 64'd0);
      check("single_count", 64'(count), 64'd0);

      // compaction: only lane 1 valid
      out_ready = 1'b0;
      set_lane(1, 64'h8000_0004, 32'h0050_0293, 1'b1, 5'd5, 64'hdead);
      cyc();
      idle();
      @(negedge clock);
      check("compact_count", 64'(count), 64'd1);
      check("compact_pc", out_pc, 64'h8000_0004);
      check("compact_waddr", 64'(out_waddr), 64'd5);
      check("compact_wdata", out_wdata, 64'hdead);
      out_ready = 1'b1;
      cyc();

`ifdef COMMIT_QUEUE_TRAP_EN
      out_ready = 1'b0;
      set_lane(0, 64'h100, 32'h13, 1'b0, 5'd0, 64'd0);
      set_lane(1, 64'h104, 32'h13, 1'b0, 5'd0, 64'd0);
      trap_valid = 1'b1;
      trap_cause = 64'h8;
      cyc();
      idle();
      @(negedge clock);
      check("trap_count", 64'(count), 64'd3);
      check("trap_ord0", out_pc, 64'h100);
      out_ready = 1'b1;
      cyc();
      @(negedge clock);
      check("trap_ord1", out_pc, 64'h104);
      cyc();
      @(negedge clock);
      check("trap_flag", 64'(out_trap), 64'd1);
      check("trap_cause", out_cause, 64'h8);
      check("trap_pc", out_pc, 64'd0);
      cyc();
`endif

      // full plus simultaneous dequeue
      out_ready = 1'b0;
      cyc();
      fill_pairs(4);
      @(negedge clock);
      check("full_count", 64'(count), 64'd8);
      check("full_stall_pc", out_pc, 64'h1000);
      set_lane(0, 64'habc0, 32'h13, 1'b0, 5'd0, 64'd0);
      out_ready = 1'b1;
      cyc();
      idle();
      out_ready = 1'b0;
      @(negedge clock);
      check("fulldeq_count", 64'(count), 64'd8);
      check("fulldeq_overflow", 64'(overflow), 64'd0);
      out_ready = 1'b1;
      repeat (7) cyc();
      @(negedge clock);
      check("fulldeq_8th", out_pc, 64'habc0);
      cyc();
      @(negedge clock);
      check("fulldeq_empty", 64'(count), 64'd0);

      // overflow: all-or-nothing drop, sticky flag
      out_ready = 1'b0;
      fill_pairs(4);
      set_lane(0, 64'hbad0, 32'h13, 1'b0, 5'd0, 64'd0);
      cyc();
      idle();
      @(negedge clock);
      check("ovf_count", 64'(count), 64'd8);
      check("ovf_flag", 64'(overflow), 64'd1);
      out_ready = 1'b1;
      repeat (8) cyc();
      @(negedge clock);
      check("ovf_drained", 64'(count), 64'd0);
      check("ovf_sticky", 64'(overflow), 64'd1);

      // reset mid-stream
      out_ready = 1'b0;
      fill_pairs(2);
      set_lane(0, 64'h2000, 32'h13, 1'b0, 5'd0, 64'd0);
      cyc();
      idle();
      @(negedge clock);
      check("mid_count5", 64'(count), 64'd5);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_valid", 64'(out_valid), 64'd0);
      check("mid_rst_count", 64'(count), 64'd0);
      check("mid_rst_overflow", 64'(overflow), 64'd0);
      @(posedge clock);
      #2 reset = 1'b1;
      set_lane(0, 64'h3000, 32'h13, 1'b1, 5'd9, 64'h77);
      cyc();
      idle();
      @(negedge clock);
      check("post_rst_valid", 64'(out_valid), 64'd1);
      check("post_rst_pc", out_pc, 64'h3000);
      check("post_rst_wdata", out_wdata, 64'h77);

      // randomized traffic: mostly-draining, then mostly-stalled
      for (int c = 0; c < 1500; c++) begin
         rand_inputs(85);
         cyc();
      end
      idle();
      @(posedge clock);
      #2 reset = 1'b0;
      @(posedge clock);
      #2 reset = 1'b1;
      for (int c = 0; c < 1500; c++) begin
         rand_inputs(35);
         cyc();
      end
      idle();
      out_ready = 1'b1;
      repeat (DEPTH + 2) cyc();
      @(negedge clock);
      check("final_empty", 64'(count), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
